branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit_pkg.sv | 19 +
 rtl/ALU_CMP_OP_ENUM.sv | 11 +
 rtl/branch_cond.sv | 34 +++
 rtl/branch_unit.sv | 70 +++++++
 tb/tb_branch_unit.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/branch_unit_pkg.sv
// Shared constants for the branch unit: compare opcodes (RISC-V funct3)
// and PC-select codes. Imported by branch_cond, branch_unit, ALU_CMP_OP_ENUM.
package branch_unit_pkg;

    localparam logic [2:0] EQ  = 3'b000;
    localparam logic [2:0] NE  = 3'b001;
    localparam logic [2:0] LT  = 3'b100;
    localparam logic [2:0] GE  = 3'b101;
    localparam logic [2:0] LTU = 3'b110;
    localparam logic [2:0] GEU = 3'b111;

    localparam logic [2:0] RSV0 = 3'b010;
    localparam logic [2:0] RSV1 = 3'b011;

    localparam logic [1:0] SEQ = 2'b00;
    localparam logic [1:0] BR  = 2'b01;
    localparam logic [1:0] JMP = 2'b10;

endpackage

// File: rtl/ALU_CMP_OP_ENUM.sv
// Constant holder exposing the compare-opcode encoding as parameters.
// No ports; values come from branch_unit_pkg.
module ALU_CMP_OP_ENUM #(
    parameter logic [2:0] EQ  = branch_unit_pkg::EQ,
    parameter logic [2:0] NE  = branch_unit_pkg::NE,
    parameter logic [2:0] LT  = branch_unit_pkg::LT,
    parameter logic [2:0] GE  = branch_unit_pkg::GE,
    parameter logic [2:0] LTU = branch_unit_pkg::LTU,
    parameter logic [2:0] GEU = branch_unit_pkg::GEU
) ();
endmodule

// File: rtl/branch_cond.sv
// Branch condition from ALU compare result and funct3 opcode.
// Ports: alu_result[XLEN], cmp_opcode[3] in; cond out (combinational).
module branch_cond
    import branch_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] alu_result,
    input  logic [2:0]      cmp_opcode,
    output logic            cond
);

    logic zero;

    assign zero = (alu_result == '0);

    // Every legal encoding is listed, so default is reached only for
    // X/Z opcodes; propagate X instead of masking it.
    always_comb begin
        cond = 1'b0;
        unique case (1'b1)
            cmp_opcode == EQ:  cond = zero;
            cmp_opcode == NE:  cond = !zero;
            cmp_opcode == LT:  cond = alu_result[0];
            cmp_opcode == GE:  cond = !alu_result[0];
            cmp_opcode == LTU: cond = alu_result[0];
            cmp_opcode == GEU: cond = !alu_result[0];
            cmp_opcode == RSV0,
            cmp_opcode == RSV1: cond = 1'b0;
            default:           cond = 1'bx;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: PC-select with jump priority, registered copy, and
// optional taken/jump counters when BRANCH_STATS_EN is defined.
// Ports: clk, rst (sync, active-high), alu_result, cmp_opcode,
// branch_jump in; branch, branch_q, [taken_cnt, jump_cnt] out.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_result,
    input  logic [2:0]      cmp_opcode,
    input  logic            branch_jump,
    output logic [1:0]      branch,
`ifdef BRANCH_STATS_EN
    output logic [1:0]      branch_q,
    output logic [31:0]     taken_cnt,
    output logic [31:0]     jump_cnt
`else
    output logic [1:0]      branch_q
`endif
);

    logic cond;

    branch_cond #(
        .XLEN       (XLEN)
    ) u_cond (
        .alu_result (alu_result),
        .cmp_opcode (cmp_opcode),
        .cond       (cond)
    );

    always_comb begin
        branch = SEQ;
        if (branch_jump)
            branch = JMP;
        else if (cond)
            branch = BR;
    end

    always_ff @(posedge clk) begin
        if (rst)
            branch_q <= SEQ;
        else
            branch_q <= branch;
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] taken_q;
    logic [31:0] jump_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_q <= '0;
            jump_q  <= '0;
        end else begin
            if (branch == BR)
                taken_q <= taken_q + 32'd1;
            if (branch == JMP)
                jump_q <= jump_q + 32'd1;
        end
    end

    assign taken_cnt = taken_q;
    assign jump_cnt  = jump_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed cases plus random
// stimulus against a behavioural model of the branch rules.
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result;
    logic [2:0]  cmp_opcode;
    logic        branch_jump;
    logic [1:0]  branch;
    logic [1:0]  branch_q;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt;
    logic [31:0] jump_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  m_q;
    logic [31:0] m_taken;
    logic [31:0] m_jump;
    bit          m_valid = 0;

    always #5 clk = ~clk;

    ALU_CMP_OP_ENUM u_ops ();

    branch_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_result  (alu_result),
        .cmp_opcode  (cmp_opcode),
        .branch_jump (branch_jump),
        .branch      (branch),
`ifdef BRANCH_STATS_EN
        .branch_q    (branch_q),
        .taken_cnt   (taken_cnt),
        .jump_cnt    (jump_cnt)
`else
        .branch_q    (branch_q)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_branch(input int op, input longint unsigned res,
                                        input bit jmp);
        bit c;
        bit odd;
        odd = (res % 2) == 1;
        case (op)
            0:       c = (res == 0);
            1:       c = (res != 0);
            4, 6:    c = odd;
            5, 7:    c = !odd;
            default: c = 0;
        endcase
        if (jmp)    return 2;
        else if (c) return 1;
        else        return 0;
    endfunction

    task automatic cycle(input bit r, input logic [2:0] op,
                         input logic [31:0] res, input bit jmp);
        int exp;
        @(negedge clk);
        if (m_valid) begin
            chk("branch_q", {30'd0, branch_q}, {30'd0, m_q});
`ifdef BRANCH_STATS_EN
            chk("taken_cnt", taken_cnt, m_taken);
            chk("jump_cnt", jump_cnt, m_jump);
`endif
        end
        rst         = r;
        cmp_opcode  = op;
        alu_result  = res;
        branch_jump = jmp;
        #1;
        exp = model_branch(int'(op), longint'(res), jmp);
        chk("branch", {30'd0, branch}, exp);
        if (r) begin
            m_q     = 2'd0;
            m_taken = 0;
            m_jump  = 0;
        end else begin
            m_q = exp[1:0];
            if (exp == 1) m_taken = m_taken + 1;
            if (exp == 2) m_jump  = m_jump + 1;
        end
        m_valid = 1;
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        alu_result = '0;
        cmp_opcode = 3'b000;
        branch_jump = 1'b0;

        cycle(1, u_ops.EQ, 32'h0, 0);
        cycle(0, u_ops.EQ, 32'h0, 0);
        cycle(0, u_ops.EQ, 32'h1, 0);
        cycle(0, u_ops.NE, 32'h1, 0);
        cycle(0, u_ops.NE, 32'h0, 0);
        cycle(0, u_ops.LT, 32'h1, 0);
        cycle(0, u_ops.LTU, 32'h1, 0);
        cycle(0, u_ops.GE, 32'h0, 0);
        cycle(0, u_ops.GEU, 32'h0, 0);
        cycle(0, u_ops.GE, 32'h1, 0);
        cycle(0, u_ops.LT, 32'hFFFF_FFFE, 0);
        cycle(0, u_ops.EQ, 32'h0, 1);
        cycle(0, 3'b010, 32'h0, 0);
        cycle(0, 3'b011, 32'h5, 0);

        cycle(1, u_ops.EQ, 32'h1, 0);
        cycle(0, u_ops.EQ, 32'h0, 0);
        cycle(0, u_ops.NE, 32'h7, 0);
        cycle(0, u_ops.LTU, 32'h1, 0);
        cycle(0, u_ops.GEU, 32'h3, 1);
        cycle(0, 3'b010, 32'h0, 0);
        cycle(0, 3'b010, 32'h0, 0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       v = 32'h0;
                1:       v = 32'h1;
                2:       v = 32'hFFFF_FFFE;
                default: v = $urandom;
            endcase
            cycle(($urandom_range(0, 15) == 0),
                  3'($urandom_range(0, 7)), v,
                  ($urandom_range(0, 3) == 0));
        end

`ifdef BRANCH_STATS_EN
        cycle(0, 3'b010, 32'h0, 0);
        @(posedge clk);
        #1;
        force dut.taken_q = 32'hFFFF_FFFF;
        #1;
        release dut.taken_q;
        m_taken = 32'hFFFF_FFFF;
        cycle(0, u_ops.EQ, 32'h0, 0);
`endif
        cycle(0, 3'b010, 32'h0, 0);
        cycle(0, 3'b010, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
